// File: rtl/atan2_pkg.sv
// atan2_pkg: shared FSM state, octant type and octant bit positions for atan2_octant_prep
package atan2_pkg;
  typedef enum logic [1:0] {IDLE, ABS, DIV, OUT} state_t;
  typedef struct packed {
    logic q_neg;
    logic i_neg;
    logic swap;
  } octant_t;
  localparam int OCT_SWAP = 0;
  localparam int OCT_INEG = 1;
  localparam int OCT_QNEG = 2;
endpackage

// File: rtl/serial_div.sv
// serial_div: restoring divider, (num << QW) / den one quotient bit per cycle MSB first, requires num < den
// ports: clk_i, reset_ni (async low), start loads num/den, busy while iterating, done on last step with quo valid
module serial_div #(
  parameter int DW = 17,
  parameter int QW = 16
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          start,
  input  logic [DW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quo
);
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);
  logic [DW:0] rem, r2, rem_n;
  logic [QW-1:0] q;
  logic [CW-1:0] cnt;
  logic ge;
  always_comb begin
    r2 = rem << 1;
    ge = r2 >= {1'b0, den};
    rem_n = ge ? r2 - {1'b0, den} : r2;
    quo = {q[QW-2:0], ge};
    done = busy && cnt == LAST;
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      rem <= '0;
      q <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem <= {1'b0, num};
      q <= '0;
      cnt <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      rem <= rem_n;
      q <= quo;
      cnt <= cnt + CW'(1);
      busy <= !done;
    end
endmodule

// File: rtl/atan2_octant_prep.sv
// atan2_octant_prep: reduces (I,Q) to octant bits and min/max magnitude ratio for an atan LUT
// ports: clk_i, reset_ni (async low), s_axis_in_* sample {Q,I} in, m_axis_out_* ratio (tdata) and octant {Q<0,I<0,|Q|>|I|} (tuser)
// ATAN2_ZERO_FLAG_EN adds m_axis_out_zero_o, high with tvalid when I == Q == 0
module atan2_octant_prep
  import atan2_pkg::*;
#(
  parameter int IN_DW = 16,
  parameter int ARG_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [2*IN_DW-1:0]   s_axis_in_tdata,
  input  logic                 s_axis_in_tvalid,
  output logic                 s_axis_in_tready,
  output logic [ARG_WIDTH-1:0] m_axis_out_tdata,
  output logic [2:0]           m_axis_out_tuser,
  output logic                 m_axis_out_tvalid,
`ifdef ATAN2_ZERO_FLAG_EN
  output logic                 m_axis_out_zero_o,
`endif
  input  logic                 m_axis_out_tready
);
  localparam logic [IN_DW:0] ONE = (IN_DW + 1)'(1);
  state_t state, state_n;
  logic [IN_DW-1:0] i_r, q_r;
  logic [IN_DW:0] abs_i, abs_q, num, den;
  logic swap, den_zero, short_path, div_start, div_busy, div_done;
  logic [ARG_WIDTH-1:0] quo;
  octant_t oct;
  assign abs_i = i_r[IN_DW-1] ? ~{1'b1, i_r} + ONE : {1'b0, i_r};
  assign abs_q = q_r[IN_DW-1] ? ~{1'b1, q_r} + ONE : {1'b0, q_r};
  assign swap = abs_q > abs_i;
  assign num = swap ? abs_i : abs_q;
  assign den = swap ? abs_q : abs_i;
  assign den_zero = den == '0;
  assign short_path = den_zero || num == den;
  assign div_start = state == ABS && !short_path;
  always_comb begin
    oct = '0;
    oct[OCT_QNEG] = q_r[IN_DW-1];
    oct[OCT_INEG] = i_r[IN_DW-1];
    oct[OCT_SWAP] = swap;
  end
  serial_div #(.DW(IN_DW + 1), .QW(ARG_WIDTH)) u_div (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .start    (div_start),
    .num      (num),
    .den      (den),
    .busy     (div_busy),
    .done     (div_done),
    .quo      (quo)
  );
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (s_axis_in_tvalid ? ABS : IDLE) :
              state == ABS  ? (short_path ? OUT : DIV) :
              state == DIV  ? (div_busy && !div_done ? DIV : OUT) :
                              (m_axis_out_tready ? IDLE : OUT);
  always_comb begin
    s_axis_in_tready = state == IDLE;
    m_axis_out_tvalid = state == OUT;
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      i_r <= '0;
      q_r <= '0;
      m_axis_out_tdata <= '0;
      m_axis_out_tuser <= '0;
    end else begin
      if (s_axis_in_tvalid && s_axis_in_tready) {q_r, i_r} <= s_axis_in_tdata;
      if (state == ABS) m_axis_out_tuser <= oct;
      if (state == ABS && short_path) m_axis_out_tdata <= den_zero ? '0 : '1;
      if (state == DIV && div_done) m_axis_out_tdata <= quo;
    end
`ifdef ATAN2_ZERO_FLAG_EN
  logic zero_r;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) zero_r <= 1'b0;
    else if (state == ABS) zero_r <= den_zero;
  assign m_axis_out_zero_o = zero_r & m_axis_out_tvalid;
`else
`endif
endmodule

// File: doc/atan2_octant_prep.md
ATAN2_OCTANT_PREP -- requirements
Module: atan2_octant_prep

Interface
REQ-001 SHALL have parameter IN_DW, default 16: signed width of each of I and Q.
REQ-002 SHALL have parameter ARG_WIDTH, default 16: unsigned ratio output width, equal to the downstream atan LUT input width.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_axis_in_tdata  input  2*IN_DW  I in [IN_DW-1:0], Q in [2*IN_DW-1:IN_DW], two's complement.
REQ-006 SHALL have port s_axis_in_tvalid  input  1  input sample valid.
REQ-007 SHALL have port s_axis_in_tready  output  1  block can accept a sample.
REQ-008 SHALL have port m_axis_out_tdata  output  ARG_WIDTH  min(|I|,|Q|)/max(|I|,|Q|) as unsigned fraction.
REQ-009 SHALL have port m_axis_out_tuser  output  3  octant {Q<0, I<0, |Q|>|I|}.
REQ-010 SHALL have port m_axis_out_tvalid  output  1  result valid.
REQ-011 SHALL have port m_axis_out_tready  input  1  downstream accepts result.

Function
REQ-012 SHALL implement FSM states IDLE, ABS, DIV, OUT.
REQ-013 SHALL assert s_axis_in_tready only in IDLE; a sample is accepted when tvalid and tready are both high.
REQ-014 IDLE SHALL capture I and Q on acceptance and go to ABS; no other state captures input.
REQ-015 ABS SHALL form |I| and |Q| in IN_DW+1 bits, so -2^(IN_DW-1) is exact; zero counts as non-negative.
REQ-016 ABS SHALL form num = min, den = max, and octant bit0 = (|Q| > |I|); equal magnitudes give bit0 = 0.
REQ-017 If den == 0, ABS SHALL set arg = 0 and go directly to OUT.
REQ-018 If num == den != 0, ABS SHALL set arg = 2^ARG_WIDTH-1 (saturated 1.0) and go directly to OUT.
REQ-019 Otherwise DIV SHALL run exactly ARG_WIDTH cycles of restoring division of (num << ARG_WIDTH) by den, one quotient bit per cycle, MSB first.
REQ-020 The quotient SHALL be truncated (floor); no rounding.
REQ-021 Latency: accept at cycle k; tvalid rises at k+ARG_WIDTH+2 for the normal path and at k+2 for the zero and equal paths.
REQ-022 OUT SHALL assert m_axis_out_tvalid and hold tdata/tuser stable until m_axis_out_tready is high, then return to IDLE in the next cycle.
REQ-023 s_axis_in_tready SHALL stay low throughout OUT, including the handshake cycle; the minimum sample spacing is ARG_WIDTH+3 cycles.

Reset
REQ-024 On reset_ni low, the FSM SHALL enter IDLE immediately, regardless of clock.
REQ-025 On reset, m_axis_out_tvalid, m_axis_out_tdata, m_axis_out_tuser and all datapath registers SHALL go to 0.
REQ-026 Reset during ABS, DIV or OUT SHALL discard the partial or pending result; no stale tvalid after release.
REQ-027 s_axis_in_tready SHALL be 1 in the first cycle after release.

Configuration
REQ-028 The macro ATAN2_ZERO_FLAG_EN, when defined, SHALL add output port m_axis_out_zero_o (1 bit).
REQ-029 m_axis_out_zero_o SHALL be high with tvalid when I == Q == 0, and otherwise low; it is 0 at reset.
REQ-030 Without ATAN2_ZERO_FLAG_EN, the port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package atan2_pkg SHALL hold the FSM state enum, the octant typedef (3-bit packed struct) and the octant bit-position constants.
REQ-032 The division SHALL be a sub-module serial_div (start/busy/done, parameterized by width); the FSM and octant logic stay in atan2_octant_prep.

Verification
REQ-033 Bench SHALL drive I=1000, Q=500 -> arg 32768, octant 3'b000, tvalid exactly 18 cycles after acceptance.
REQ-034 Bench SHALL drive I=-1200, Q=-300 -> arg 16384, octant 3'b110.
REQ-035 Bench SHALL drive I=100, Q=300 -> arg 21845, octant 3'b001; then I=-32768, Q=-32768 -> arg 65535, octant 3'b110, tvalid 2 cycles after acceptance.
REQ-036 Bench SHALL drive I=0, Q=0 -> arg 0, octant 3'b000, tvalid after 2 cycles; with ATAN2_ZERO_FLAG_EN also zero_o=1.
REQ-037 Bench SHALL hold m_axis_out_tready low for 10 cycles in OUT -> tdata/tuser stable, s_axis_in_tready low; releasing it completes one handshake only.
REQ-038 Bench SHALL assert reset_ni low mid-DIV (cycle k+8) -> tvalid 0 at once, s_axis_in_tready 1 after release, next sample yields its correct result.
